shape_seq_unit: RTL and testbench
=================================

# shape_seq_unit

Sequential, parametrised successor to the combinational shape-arithmetic primitives (multiply, divide, power, half-product area, axis distance, compare). One engine is time-shared across eight operations behind a valid/ready command port and a valid/ready result port. Divide and power run as multi-cycle iterations. The block sits between the SPU instruction decoder and the shape result register file.

## Interface
Parameters:
- `N`, 32, operand/result width (≥4).
- `EXP_MAX`, 31, largest exponent accepted by POW.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command valid.
- `in_ready` out 1: command accepted when `in_valid && in_ready` at a rising edge.
- `op` in 3: operation code, see Operation.
- `a` in N: operand A, unsigned.
- `b` in N: operand B, unsigned.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result when `out_valid && out_ready`.
- `res` out N: result.
- `ovf` out 1: result truncated (overflow).
- `err` out 1: illegal operand (divide by zero, or exponent above `EXP_MAX`).
- `busy` out 1: high in EXEC or DONE.

## Operation
- States are IDLE, EXEC and DONE. Reset state is IDLE.
- Reset values: `in_ready` 1, `out_valid` 0, `res` 0, `ovf` 0, `err` 0, `busy` 0.
- IDLE:
  - `in_ready` = 1.
  - On handshake: latch `op`, `a` and `b`; clear `ovf` and `err`; go to EXEC.
  - Inputs are not sampled in any other state.
- EXEC:
  - `in_ready` = 0.
  - Runs the latched op. Goes to DONE on the edge that completes it.
- DONE:
  - `out_valid` = 1. `res`, `ovf` and `err` are held stable.
  - On `out_ready`: go to IDLE and clear `out_valid`.
- Op codes (all arithmetic is unsigned; P is the 2N-bit product):
  - 000 MUL: `res` = P[N-1:0] of a*b. `ovf` = |P[2N-1:N].
  - 001 DIV: restoring division, one quotient bit per cycle, MSB first; `res` = quotient floor(a/b).
    - b = 0: skip iteration, `res` = all ones, `err` = 1.
  - 010 POW: `res` = a^b by repeated multiply, one multiply per cycle. The accumulator starts at 1.
    - b = 0: `res` = 1.
    - b > `EXP_MAX`: no iteration, `res` = all ones, `err` = 1.
    - `ovf` is sticky. It is set if any intermediate product has nonzero high half. On overflow, iteration continues on the truncated value.
  - 011 TRI: `res` = P[N:1] of a*b (triangle area). `ovf` = |P[2N-1:N+1].
  - 100 DXY: `res` = |a−b|.
  - 101 SQR: `res` = low half of a*a. `ovf` as for MUL.
  - 110 AVG: `res` = (a+b)>>1, computed in N+1 bits, so no overflow.
  - 111 CMP: `res` = {N−2 zeros, code}, where code is 00 for a==b, 01 for a>b, 10 for a<b.

## Timing
- Edge E0 is the command handshake. Latency is measured from E0 to the first edge at which `out_valid` is sampled high.
  - MUL, TRI, DXY, SQR, AVG, CMP: 2 cycles.
  - DIV: N+1 cycles (33 at default). With b=0: 2 cycles.
  - POW: max(b,1)+1 cycles. With b > `EXP_MAX`: 2 cycles.
- Result handshake at edge Ek: `out_valid` is 0 after Ek, and `in_ready` is 1 after Ek. A new command can be accepted no earlier than Ek+1.
  - There is no overlap of commands.
  - Minimum initiation interval is latency + 1 cycles.
- Backpressure: `out_ready` low holds DONE indefinitely with `res`, `ovf` and `err` unchanged.
- `in_valid` while busy is ignored. The command is not queued, and the upstream must hold it until `in_ready`.
- Changes on `a`, `b` or `op` after E0 do not affect the running operation.
- `rst_n` low at any time, including mid-DIV or mid-POW or in DONE:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The operation is discarded.
  - The first command can be accepted on the first rising edge after `rst_n` deasserts.
- `busy` = (state != IDLE). It is a registered output.

## Test plan
- MUL a=7, b=6 → `res`=42, `ovf`=0, `err`=0, `out_valid` 2 cycles after E0. MUL a=0x10000, b=0x10000 → `res`=0, `ovf`=1.
- DIV a=100, b=7 → `res`=14 after 33 cycles. DIV a=5, b=0 → `res`=0xFFFFFFFF, `err`=1 after 2 cycles.
- POW a=3, b=4 → `res`=81 after 5 cycles. POW a=3, b=0 → `res`=1. POW a=2, b=32 → `err`=1, `res`=0xFFFFFFFF. POW a=2, b=31 → `res`=0x80000000, `ovf`=0.
- CMP a=0xFFFFFFFC, b=4 → `res`=1. DXY a=4, b=0xFFFFFFFC → `res`=0xFFFFFFF8. AVG a=0xFFFFFFFF, b=1 → `res`=0x80000000. TRI a=9, b=5 → `res`=22.
- Backpressure: MUL 3*5 with `out_ready` low for 6 cycles → `res`=15 stable, `in_ready`=0, and an `in_valid` pulse meanwhile is ignored. After `out_ready`, the next command is accepted one cycle later.
- Reset mid-DIV (cycle 10): all outputs at their reset values immediately. After release, MUL 2*2 → `res`=4 with normal latency.

Source files
------------

// File: rtl/shape_seq_unit.sv
// shape_seq_unit
//   Time-shared shape-arithmetic engine. It takes one command at a time through
//   a valid/ready command port and returns one result through a valid/ready
//   result port. The operations are MUL, DIV, POW, TRI, DXY, SQR, AVG and CMP.
//   DIV produces one quotient bit per cycle. POW does one multiply per cycle.
//   All other operations finish in a single execute cycle.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready command handshake; op/a/b are sampled only in IDLE
//   op, a, b           operation code and unsigned operands
//   out_valid, out_ready result handshake; res/ovf/err are held until accepted
//   res, ovf, err      result, truncation flag, illegal-operand flag
//   busy               registered, high while state != IDLE
module shape_seq_unit #(
  parameter int N       = 32,
  parameter int EXP_MAX = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL = 3'b000, OP_DIV = 3'b001, OP_POW = 3'b010, OP_TRI = 3'b011,
    OP_DXY = 3'b100, OP_SQR = 3'b101, OP_AVG = 3'b110, OP_CMP = 3'b111
  } op_t;

  localparam logic [N-1:0] EXP_LIM  = N'(EXP_MAX);
  localparam logic [N-1:0] DIV_LAST = N'(N - 1);

  state_t         state;
  op_t            op_r;
  logic [N-1:0]   a_r, b_r;
  logic [N-1:0]   acc;       // POW accumulator
  logic [N-1:0]   rem, quo;  // DIV partial remainder / dividend-quotient shifter
  logic [N-1:0]   cnt;       // DIV bit index (up) or POW multiplies left (down)

  logic [N-1:0]   mul_x, mul_y;
  logic [2*N-1:0] prod;
  logic [N:0]     div_tmp;
  logic           div_ge;
  logic           exp_big;
  logic [1:0]     cmp_code;
  logic [N-1:0]   avg_val;
  logic           exec_last;

  // A single shared multiplier; operand selection depends on the latched op.
  always_comb begin
    mul_x = a_r;
    mul_y = b_r;
    case (op_r)
      OP_SQR:  mul_y = a_r;
      OP_POW: begin
        mul_x = acc;
        mul_y = a_r;
      end
      default: ;
    endcase
    prod = (2*N)'(mul_x) * (2*N)'(mul_y);

    div_tmp = {rem, quo[N-1]};
    div_ge  = (div_tmp >= {1'b0, b_r});
    exp_big = (b_r > EXP_LIM);

    if (a_r == b_r)     cmp_code = 2'b00;
    else if (a_r > b_r) cmp_code = 2'b01;
    else                cmp_code = 2'b10;

    // (a+b)>>1 without needing an N+1-bit sum: halve first, restore the carry.
    avg_val = (a_r >> 1) + (b_r >> 1) + N'(a_r[0] & b_r[0]);

    exec_last = 1'b1;
    case (op_r)
      OP_DIV: exec_last = (b_r == '0) || (cnt == DIV_LAST);
      OP_POW: exec_last = exp_big || (b_r == '0) || (cnt == N'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= OP_MUL;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= op_t'(op);
            a_r      <= a;
            b_r      <= b;
            acc      <= N'(1);
            rem      <= '0;
            quo      <= a;
            cnt      <= (op_t'(op) == OP_POW) ? b : '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end

        EXEC: begin
          case (op_r)
            OP_MUL, OP_SQR: begin
              res <= prod[N-1:0];
              ovf <= |prod[2*N-1:N];
            end
            OP_TRI: begin
              res <= prod[N:1];
              ovf <= |prod[2*N-1:N+1];
            end
            OP_DXY: res <= (a_r >= b_r) ? (a_r - b_r) : (b_r - a_r);
            OP_AVG: res <= avg_val;
            OP_CMP: res <= {{(N-2){1'b0}}, cmp_code};
            OP_DIV: begin
              if (b_r == '0) begin
                res <= '1;
                err <= 1'b1;
              end else begin
                // Restoring step: shift in the next dividend bit, subtract if it fits.
                rem <= div_ge ? N'(div_tmp - {1'b0, b_r}) : div_tmp[N-1:0];
                quo <= {quo[N-2:0], div_ge};
                cnt <= cnt + N'(1);
                if (cnt == DIV_LAST) res <= {quo[N-2:0], div_ge};
              end
            end
            OP_POW: begin
              if (exp_big) begin
                res <= '1;
                err <= 1'b1;
              end else if (b_r == '0) begin
                res <= N'(1);
              end else begin
                acc <= prod[N-1:0];
                ovf <= ovf | (|prod[2*N-1:N]);
                cnt <= cnt - N'(1);
                if (cnt == N'(1)) res <= prod[N-1:0];
              end
            end
            default: ;
          endcase
          if (exec_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_seq_unit.sv
// Scoreboard bench for shape_seq_unit at default parameters (N=32, EXP_MAX=31).
// Each command pushes its expected result and latency. The collector pops that
// entry when out_valid appears and compares it against the DUT outputs.
module tb_shape_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        ovf, err, busy;

  shape_seq_unit #(.N(32), .EXP_MAX(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .ovf(ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Drives one command and returns right after its handshake edge (+1).
  task automatic send(input string tag, input logic [2:0] o, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] er, input logic eo,
                      input logic ee, input int lat, input bit push, output int waited);
    exp_t e;
    int   g;
    if (push) begin
      e.tag = tag; e.res = er; e.ovf = eo; e.err = ee; e.lat = lat;
      exp_q.push_back(e);
    end
    in_valid = 1'b1; op = o; a = av; b = bv;
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    waited = g;
    if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;          // E0
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;  // must not disturb the running op
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready_low"}, in_ready, 0);
  endtask

  // Waits for the result, compares it, optionally holds backpressure, then accepts it.
  task automatic collect(input int hold);
    exp_t        e;
    int          k;
    logic [31:0] r0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_result", out_valid, 0);
      return;
    end
    e = exp_q.pop_front();
    if (!out_valid) begin
      chk({e.tag, "_result_timeout"}, 0, 1);
      return;
    end
    chk({e.tag, "_res"}, res, e.res);
    chk({e.tag, "_ovf"}, ovf, e.ovf);
    chk({e.tag, "_err"}, err, e.err);
    chk({e.tag, "_lat"}, k + 1, e.lat);
    r0 = res;
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin in_valid = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1; end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      chk({e.tag, "_hold_res"}, res, r0);
      chk({e.tag, "_hold_valid"}, out_valid, 1);
      chk({e.tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;          // Ek
    out_ready = 1'b0;
    chk({e.tag, "_post_valid"}, out_valid, 0);
    chk({e.tag, "_post_in_ready"}, in_ready, 1);
    chk({e.tag, "_post_busy"}, busy, 0);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] er, input logic eo,
                     input logic ee, input int lat);
    int w;
    send(tag, o, av, bv, er, eo, ee, lat, 1'b1, w);
    collect(0);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb;
    int          w;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("mul", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 2);
    run("mul_ovf", 3'b000, 32'h10000, 32'h10000, 32'd0, 1'b1, 1'b0, 2);
    run("div", 3'b001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    run("div0", 3'b001, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 2);
    run("pow", 3'b010, 32'd3, 32'd4, 32'd81, 1'b0, 1'b0, 5);
    run("pow_b0", 3'b010, 32'd3, 32'd0, 32'd1, 1'b0, 1'b0, 2);
    run("pow_big", 3'b010, 32'd2, 32'd32, 32'hFFFFFFFF, 1'b0, 1'b1, 2);
    run("pow_max", 3'b010, 32'd2, 32'd31, 32'h80000000, 1'b0, 1'b0, 32);
    run("pow_ovf", 3'b010, 32'd65536, 32'd3, 32'd0, 1'b1, 1'b0, 4);
    run("cmp_gt", 3'b111, 32'hFFFFFFFC, 32'd4, 32'd1, 1'b0, 1'b0, 2);
    run("cmp_lt", 3'b111, 32'd4, 32'd9, 32'd2, 1'b0, 1'b0, 2);
    run("cmp_eq", 3'b111, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 2);
    run("dxy", 3'b100, 32'd4, 32'hFFFFFFFC, 32'hFFFFFFF8, 1'b0, 1'b0, 2);
    run("avg", 3'b110, 32'hFFFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 2);
    run("tri", 3'b011, 32'd9, 32'd5, 32'd22, 1'b0, 1'b0, 2);
    run("tri_ovf", 3'b011, 32'h80000000, 32'd4, 32'd0, 1'b1, 1'b0, 2);
    run("sqr", 3'b101, 32'h10001, 32'h5, 32'h20001, 1'b1, 1'b0, 2);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom_range(1, 1000);
      run("div_rand", 3'b001, ra, rb, ra / rb, 1'b0, 1'b0, 33);
      ra = $urandom; rb = $urandom;
      p = {32'd0, ra} * {32'd0, rb};
      run("mul_rand", 3'b000, ra, rb, p[31:0], |p[63:32], 1'b0, 2);
    end

    // Backpressure, then the next command must be accepted without any wait.
    send("bp_mul", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 2, 1'b1, w);
    collect(6);
    send("bp_next", 3'b000, 32'd2, 32'd3, 32'd6, 1'b0, 1'b0, 2, 1'b1, w);
    chk("bp_next_wait", w, 0);
    collect(0);

    // Reset in the middle of a DIV; nothing is pushed because the result is discarded.
    send("div_rst", 3'b001, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 0, 1'b0, w);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    run("mul_after_rst", 3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 2);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
